// File: rtl/rocc_resp_tracker_pkg.sv
// rocc_resp_tracker_pkg: shared RoCC command/response/tag types for the response tracker.
package rocc_resp_tracker_pkg;
   localparam int TRANS_ID_BITS = 5;
   typedef struct packed {
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [31:0] instr;
   } rocc_cmd_t;
   typedef struct packed {
      logic [63:0] resp_data;
   } rocc_resp_t;
   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic                     kill;
   } rocc_tag_t;
   typedef struct packed {
      rocc_cmd_t                cmd;
      logic [TRANS_ID_BITS-1:0] trans_id;
   } cmd_entry_t;
endpackage

// File: rtl/rocc_resp_tracker_fifo.sv
// rocc_fifo: parameterised circular FIFO with synchronous flush; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module rocc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr, r_rptr;
   logic [PW:0]      r_cnt;
   logic             w_push, w_pop;
   assign o_full  = r_cnt == (PW+1)'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign w_pop   = i_pop & !o_empty;
   assign w_push  = i_push & (!o_full | w_pop);
   assign o_data  = r_mem[r_rptr];
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         r_wptr <= r_wptr + PW'(w_push);
         r_rptr <= r_rptr + PW'(w_pop);
         r_cnt  <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
   end
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end
endmodule

// File: rtl/rocc_resp_tracker.sv
// rocc_resp_tracker: buffers RoCC commands, tracks in-flight trans_ids in order and
// returns each accelerator response as a registered writeback; flush drains late responses.
module rocc_resp_tracker
   import rocc_resp_tracker_pkg::*;
#(
   parameter int CMD_DEPTH       = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  rocc_cmd_t                cmd_i,
   input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
   input  logic                     cmd_valid_i,
   output logic                     cmd_ready_o,
   output rocc_cmd_t                acc_cmd_o,
   output logic                     acc_cmd_valid_o,
   input  logic                     acc_cmd_ready_i,
   input  rocc_resp_t               acc_resp_i,
   input  logic                     acc_resp_valid_i,
   output logic                     acc_resp_ready_o,
   output logic [63:0]              result_o,
   output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
   output logic                     result_valid_o,
   output logic                     busy_o
);
   localparam int TW = $clog2(MAX_OUTSTANDING);
   cmd_entry_t                 w_cmd_head;
   rocc_tag_t                  w_tag_head;
   logic [TRANS_ID_BITS-1:0]   w_tag_id;
   logic                       w_cmd_full, w_cmd_empty, w_tag_full, w_tag_empty;
   logic                       w_cmd_push, w_cmd_pop, w_resp_hs, w_wb;
   logic [MAX_OUTSTANDING-1:0] r_kill;
   logic [TW-1:0]              r_slot_w, r_slot_r;
   logic [63:0]                r_result;
   logic [TRANS_ID_BITS-1:0]   r_result_id;
   logic                       r_valid;
   assign cmd_ready_o      = !w_cmd_full;
   assign w_cmd_push       = cmd_valid_i & !w_cmd_full & !flush_i;
   assign w_resp_hs        = acc_resp_valid_i & !w_tag_empty;
   // a response popping a tag frees a slot for the next command in the same cycle
   assign acc_cmd_valid_o  = !w_cmd_empty & (!w_tag_full | w_resp_hs);
   assign w_cmd_pop        = acc_cmd_valid_o & acc_cmd_ready_i;
   assign acc_cmd_o        = w_cmd_head.cmd;
   assign acc_resp_ready_o = !w_tag_empty;
   assign w_tag_head       = '{trans_id: w_tag_id, kill: r_kill[r_slot_r]};
   assign w_wb             = w_resp_hs & !w_tag_head.kill & !flush_i;
   assign result_o         = r_result;
   assign result_trans_id_o = r_result_id;
   assign result_valid_o   = r_valid & !flush_i;
   assign busy_o           = !w_cmd_empty | !w_tag_empty;
   rocc_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_flush (flush_i),
      .i_push  (w_cmd_push),
      .i_data  ({cmd_i, cmd_trans_id_i}),
      .i_pop   (w_cmd_pop),
      .o_data  (w_cmd_head),
      .o_full  (w_cmd_full),
      .o_empty (w_cmd_empty)
   );
   rocc_fifo #(.WIDTH(TRANS_ID_BITS), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_flush (1'b0),
      .i_push  (w_cmd_pop),
      .i_data  (w_cmd_head.trans_id),
      .i_pop   (w_resp_hs),
      .o_data  (w_tag_id),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty)
   );
   // kill bits shadow the tag queue slots; a tag issued during flush is born killed
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_kill   <= '0;
         r_slot_w <= '0;
         r_slot_r <= '0;
      end else begin
         r_slot_w <= r_slot_w + TW'(w_cmd_pop);
         r_slot_r <= r_slot_r + TW'(w_resp_hs);
         if (flush_i) r_kill <= '1;
         if (w_cmd_pop) r_kill[r_slot_w] <= flush_i;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_valid     <= 1'b0;
         r_result    <= '0;
         r_result_id <= '0;
      end else begin
         r_valid <= w_wb;
         if (w_wb) begin
            r_result    <= acc_resp_i.resp_data;
            r_result_id <= w_tag_head.trans_id;
         end
      end
   end
endmodule

// File: tb/tb_rocc_resp_tracker.sv
// tb_rocc_resp_tracker: table-driven vectors plus directed sequences for backpressure,
// flush and asynchronous reset corner cases.
module tb_rocc_resp_tracker;
   import rocc_resp_tracker_pkg::*;
   logic                     clk, rst_i, flush_i, cmd_valid_i, cmd_ready_o;
   logic                     acc_cmd_valid_o, acc_cmd_ready_i, acc_resp_valid_i, acc_resp_ready_o;
   logic                     result_valid_o, busy_o;
   rocc_cmd_t                cmd_i, acc_cmd_o;
   rocc_resp_t               acc_resp_i;
   logic [TRANS_ID_BITS-1:0] cmd_trans_id_i, result_trans_id_o;
   logic [63:0]              result_o;
   int                       total = 0, bad = 0;

   rocc_resp_tracker #(.CMD_DEPTH(2), .MAX_OUTSTANDING(4)) dut (
      .clk_i             (clk),
      .rst_i             (rst_i),
      .flush_i           (flush_i),
      .cmd_i             (cmd_i),
      .cmd_trans_id_i    (cmd_trans_id_i),
      .cmd_valid_i       (cmd_valid_i),
      .cmd_ready_o       (cmd_ready_o),
      .acc_cmd_o         (acc_cmd_o),
      .acc_cmd_valid_o   (acc_cmd_valid_o),
      .acc_cmd_ready_i   (acc_cmd_ready_i),
      .acc_resp_i        (acc_resp_i),
      .acc_resp_valid_i  (acc_resp_valid_i),
      .acc_resp_ready_o  (acc_resp_ready_o),
      .result_o          (result_o),
      .result_trans_id_o (result_trans_id_o),
      .result_valid_o    (result_valid_o),
      .busy_o            (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl, cv;
      logic [4:0]  id;
      logic        ar, rv;
      logic [63:0] rd;
      logic        cr, av;
      logic [4:0]  aid;
      logic        rr, wv;
      logic [4:0]  wid;
      logic [63:0] wd;
      logic        bz;
   } vec_t;
   vec_t vecs [20];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic fl, input logic cv, input logic [4:0] id,
                        input logic ar, input logic rv, input logic [63:0] rd);
      flush_i          = fl;
      cmd_valid_i      = cv;
      cmd_trans_id_i   = id;
      cmd_i            = '{rs1: 64'h100 + 64'(id), rs2: 64'h0, instr: 32'h0000_000B};
      acc_cmd_ready_i  = ar;
      acc_resp_valid_i = rv;
      acc_resp_i       = '{resp_data: rd};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0);
   endtask

   task automatic run_vec(input vec_t v, input int i);
      drive(v.fl, v.cv, v.id, v.ar, v.rv, v.rd);
      #1;
      chk($sformatf("v%0d.cmd_ready", i), 64'(cmd_ready_o), 64'(v.cr));
      chk($sformatf("v%0d.acc_valid", i), 64'(acc_cmd_valid_o), 64'(v.av));
      if (v.av) chk($sformatf("v%0d.acc_rs1", i), acc_cmd_o.rs1, 64'h100 + 64'(v.aid));
      chk($sformatf("v%0d.resp_ready", i), 64'(acc_resp_ready_o), 64'(v.rr));
      chk($sformatf("v%0d.wb_valid", i), 64'(result_valid_o), 64'(v.wv));
      if (v.wv) begin
         chk($sformatf("v%0d.wb_id", i), 64'(result_trans_id_o), 64'(v.wid));
         chk($sformatf("v%0d.wb_data", i), result_o, v.wd);
      end
      chk($sformatf("v%0d.busy", i), 64'(busy_o), 64'(v.bz));
      tick();
   endtask

   initial begin
      // single command id3, response two cycles after issue
      vecs[0]  = '{0,1,3,1,0,0,       1,0,0,0,0,0,0,0};
      vecs[1]  = '{0,0,0,1,0,0,       1,1,3,0,0,0,0,1};
      vecs[2]  = '{0,0,0,1,0,0,       1,0,0,1,0,0,0,1};
      vecs[3]  = '{0,0,0,1,1,'hABCD,  1,0,0,1,0,0,0,1};
      vecs[4]  = '{0,0,0,1,0,0,       1,0,0,0,1,3,'hABCD,0};
      vecs[5]  = '{0,0,0,1,0,0,       1,0,0,0,0,0,0,0};
      // five commands against four tag slots, then in-order responses
      vecs[6]  = '{0,1,0,1,0,0,       1,0,0,0,0,0,0,0};
      vecs[7]  = '{0,1,1,1,0,0,       1,1,0,0,0,0,0,1};
      vecs[8]  = '{0,1,2,1,0,0,       1,1,1,1,0,0,0,1};
      vecs[9]  = '{0,1,3,1,0,0,       1,1,2,1,0,0,0,1};
      vecs[10] = '{0,1,4,1,0,0,       1,1,3,1,0,0,0,1};
      vecs[11] = '{0,0,0,1,0,0,       1,0,0,1,0,0,0,1};
      vecs[12] = '{0,0,0,1,0,0,       1,0,0,1,0,0,0,1};
      vecs[13] = '{0,0,0,1,1,'hD0,    1,1,4,1,0,0,0,1};
      vecs[14] = '{0,0,0,1,1,'hD1,    1,0,0,1,1,0,'hD0,1};
      vecs[15] = '{0,0,0,1,1,'hD2,    1,0,0,1,1,1,'hD1,1};
      vecs[16] = '{0,0,0,1,1,'hD3,    1,0,0,1,1,2,'hD2,1};
      vecs[17] = '{0,0,0,1,1,'hD4,    1,0,0,1,1,3,'hD3,1};
      vecs[18] = '{0,0,0,1,0,0,       1,0,0,0,1,4,'hD4,0};
      vecs[19] = '{0,0,0,1,0,0,       1,0,0,0,0,0,0,0};

      rst_i = 1'b1;
      idle();
      tick();
      tick();
      chk("rst.cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst.acc_valid", 64'(acc_cmd_valid_o), 64'd0);
      chk("rst.resp_ready", 64'(acc_resp_ready_o), 64'd0);
      chk("rst.wb_valid", 64'(result_valid_o), 64'd0);
      chk("rst.result", result_o, 64'd0);
      chk("rst.result_id", 64'(result_trans_id_o), 64'd0);
      chk("rst.busy", 64'(busy_o), 64'd0);
      #2 rst_i = 1'b0;
      tick();

      for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

      // backpressure: third command held until the FIFO drains
      drive(0, 1, 8, 0, 0, 0);  #1 chk("bp.ready0", 64'(cmd_ready_o), 64'd1); tick();
      drive(0, 1, 9, 0, 0, 0);  #1 chk("bp.head8", acc_cmd_o.rs1, 64'h108); tick();
      drive(0, 1, 10, 0, 0, 0); #1 chk("bp.full", 64'(cmd_ready_o), 64'd0); tick();
      drive(0, 1, 10, 1, 0, 0); #1 chk("bp.full_pop", 64'(cmd_ready_o), 64'd0);
      chk("bp.issue8", acc_cmd_o.rs1, 64'h108); tick();
      #1 chk("bp.ready1", 64'(cmd_ready_o), 64'd1);
      chk("bp.issue9", acc_cmd_o.rs1, 64'h109); tick();
      drive(0, 0, 0, 1, 0, 0);  #1 chk("bp.issue10", acc_cmd_o.rs1, 64'h10A);
      chk("bp.valid10", 64'(acc_cmd_valid_o), 64'd1); tick();
      drive(0, 0, 0, 0, 1, 'h80); #1 chk("bp.drained", 64'(acc_cmd_valid_o), 64'd0); tick();
      drive(0, 0, 0, 0, 1, 'h90); #1 chk("bp.wb8", 64'(result_trans_id_o), 64'd8);
      chk("bp.wb8v", 64'(result_valid_o), 64'd1); tick();
      drive(0, 0, 0, 0, 1, 'hA0); #1 chk("bp.wb9", 64'(result_trans_id_o), 64'd9); tick();
      idle(); #1 chk("bp.wb10", 64'(result_trans_id_o), 64'd10);
      chk("bp.wb10d", result_o, 64'hA0);
      chk("bp.busy", 64'(busy_o), 64'd0); tick();

      // flush with two outstanding and one buffered
      drive(0, 1, 1, 0, 0, 0); tick();
      drive(0, 1, 2, 1, 0, 0); #1 chk("fl.issue1", acc_cmd_o.rs1, 64'h101); tick();
      drive(0, 1, 3, 1, 0, 0); #1 chk("fl.issue2", acc_cmd_o.rs1, 64'h102); tick();
      drive(1, 0, 0, 0, 0, 0); #1 chk("fl.buffered", 64'(acc_cmd_valid_o), 64'd1); tick();
      drive(0, 0, 0, 1, 0, 0); #1 chk("fl.killed_cmd", 64'(acc_cmd_valid_o), 64'd0);
      chk("fl.resp_ready", 64'(acc_resp_ready_o), 64'd1);
      chk("fl.busy", 64'(busy_o), 64'd1); tick();
      drive(0, 0, 0, 1, 1, 'h11); #1 chk("fl.no_issue", 64'(acc_cmd_valid_o), 64'd0); tick();
      drive(0, 0, 0, 1, 1, 'h22); #1 chk("fl.drop1", 64'(result_valid_o), 64'd0);
      chk("fl.resp_ready2", 64'(acc_resp_ready_o), 64'd1); tick();
      idle(); #1 chk("fl.drop2", 64'(result_valid_o), 64'd0);
      chk("fl.idle_busy", 64'(busy_o), 64'd0); tick();

      // issue in the flush cycle, then a normal command
      drive(0, 1, 6, 0, 0, 0); tick();
      drive(1, 0, 0, 1, 0, 0); #1 chk("fp.issue6", acc_cmd_o.rs1, 64'h106); tick();
      drive(0, 1, 7, 1, 0, 0); #1 chk("fp.tag6", 64'(acc_resp_ready_o), 64'd1); tick();
      drive(0, 0, 0, 1, 1, 'h66); #1 chk("fp.issue7", acc_cmd_o.rs1, 64'h107); tick();
      drive(0, 0, 0, 0, 1, 'h77); #1 chk("fp.drop6", 64'(result_valid_o), 64'd0); tick();
      idle(); #1 chk("fp.wb7v", 64'(result_valid_o), 64'd1);
      chk("fp.wb7", 64'(result_trans_id_o), 64'd7);
      chk("fp.wb7d", result_o, 64'h77); tick();

      // response handshake coincident with flush
      drive(0, 1, 9, 1, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(1, 0, 0, 1, 1, 'h99); #1 chk("fr.ready", 64'(acc_resp_ready_o), 64'd1); tick();
      idle(); #1 chk("fr.no_wb", 64'(result_valid_o), 64'd0); tick();

      // flush in the strobe cycle masks the writeback
      drive(0, 1, 10, 1, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      drive(0, 0, 0, 1, 1, 'hAA); tick();
      drive(1, 0, 0, 0, 0, 0); #1 chk("fm.masked", 64'(result_valid_o), 64'd0); tick();
      idle(); #1 chk("fm.after", 64'(result_valid_o), 64'd0); tick();

      // asynchronous reset with two commands outstanding
      drive(0, 1, 1, 0, 0, 0); tick();
      drive(0, 1, 2, 1, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0); tick();
      idle(); #1 chk("ar.pre_busy", 64'(busy_o), 64'd1);
      #1 rst_i = 1'b1;
      #1 chk("ar.resp_ready", 64'(acc_resp_ready_o), 64'd0);
      chk("ar.busy", 64'(busy_o), 64'd0);
      chk("ar.result", result_o, 64'd0);
      chk("ar.result_id", 64'(result_trans_id_o), 64'd0);
      chk("ar.cmd_ready", 64'(cmd_ready_o), 64'd1);
      tick();
      rst_i = 1'b0;
      drive(0, 0, 0, 0, 1, 'h55); #1 chk("ar.no_accept", 64'(acc_resp_ready_o), 64'd0); tick();
      idle(); #1 chk("ar.no_wb", 64'(result_valid_o), 64'd0); tick();
      drive(0, 1, 5, 1, 0, 0); tick();
      drive(0, 0, 0, 1, 0, 0); #1 chk("ar.issue5", acc_cmd_o.rs1, 64'h105); tick();
      drive(0, 0, 0, 0, 1, 'h5555); #1 chk("ar.ready5", 64'(acc_resp_ready_o), 64'd1); tick();
      idle(); #1 chk("ar.wb5", 64'(result_trans_id_o), 64'd5);
      chk("ar.wb5d", result_o, 64'h5555);
      chk("ar.wb5v", 64'(result_valid_o), 64'd1); tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
